// File: rtl/ext_irq_ctrl.sv
// Lite platform-level interrupt controller: level gateways, per-context priority
// arbitration and claim/complete, exposed through a word-wide register port.
module ext_irq_ctrl #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   irq_src,
  input  logic              reg_re,
  input  logic              reg_we,
  input  logic [7:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_ack,
  output logic              m_ext_int,
  output logic              s_ext_int
);

  localparam int ID_W = $clog2(NSRC + 1);

  // Register port: a request (reg_re or reg_we, never both) is sampled on a
  // posedge and answered by a one-cycle reg_ack with reg_rdata on the next cycle.

  logic [PRIO_W-1:0] prio [1:NSRC];
  logic [NSRC:1]     pending, in_flight, m_en, s_en;
  logic [PRIO_W-1:0] m_thr, s_thr;
  logic [ID_W-1:0]   m_best_q, s_best_q, m_best_c, s_best_c;
  logic [PRIO_W-1:0] m_bp, s_bp;
  logic              m_hit, s_hit, m_claim, s_claim;
  logic [NSRC:1]     clm_vec, cmp_vec;
  logic [31:0]       rd_c;

  // Seeding the running best with the threshold admits only prio > threshold;
  // a strict compare keeps the lowest ID on ties.
  always_comb begin
    m_best_c = '0;
    s_best_c = '0;
    m_bp     = m_thr;
    s_bp     = s_thr;
    for (int i = 1; i <= NSRC; i++) begin
      if (pending[i] && m_en[i] && prio[i] > m_bp) begin
        m_bp     = prio[i];
        m_best_c = ID_W'(i);
      end
      if (pending[i] && s_en[i] && prio[i] > s_bp) begin
        s_bp     = prio[i];
        s_best_c = ID_W'(i);
      end
    end
  end

  // A claim only succeeds if the registered winner is still pending; this makes
  // a claim racing a just-claimed ID return 0 with no side effect.
  always_comb begin
    m_hit = 1'b0;
    s_hit = 1'b0;
    for (int i = 1; i <= NSRC; i++) begin
      if (m_best_q == ID_W'(i) && pending[i]) m_hit = 1'b1;
      if (s_best_q == ID_W'(i) && pending[i]) s_hit = 1'b1;
    end
    m_claim = reg_re && (reg_addr == 8'h94) && m_hit;
    s_claim = reg_re && (reg_addr == 8'h98) && s_hit && !(m_claim && m_best_q == s_best_q);
    clm_vec = '0;
    cmp_vec = '0;
    for (int i = 1; i <= NSRC; i++) begin
      clm_vec[i] = (m_claim && m_best_q == ID_W'(i)) || (s_claim && s_best_q == ID_W'(i));
      cmp_vec[i] = reg_we && (reg_addr == 8'h94 || reg_addr == 8'h98) &&
                   (reg_wdata == 32'(i)) && in_flight[i];
    end
  end

  always_comb begin
    rd_c = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (reg_addr == 8'(4 * i)) rd_c = 32'(prio[i]);
    end
    case (reg_addr)
      8'h80:   rd_c = 32'({pending, 1'b0});
      8'h84:   rd_c = 32'({m_en, 1'b0});
      8'h88:   rd_c = 32'({s_en, 1'b0});
      8'h8C:   rd_c = 32'(m_thr);
      8'h90:   rd_c = 32'(s_thr);
      8'h94:   rd_c = m_claim ? 32'(m_best_q) : '0;
      8'h98:   rd_c = s_claim ? 32'(s_best_q) : '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i <= NSRC; i++) prio[i] <= '0;
      pending   <= '0;
      in_flight <= '0;
      m_en      <= '0;
      s_en      <= '0;
      m_thr     <= '0;
      s_thr     <= '0;
      m_best_q  <= '0;
      s_best_q  <= '0;
      m_ext_int <= 1'b0;
      s_ext_int <= 1'b0;
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack   <= reg_re | reg_we;
      reg_rdata <= reg_re ? rd_c : '0;
      if (reg_we) begin
        for (int i = 1; i <= NSRC; i++) begin
          if (reg_addr == 8'(4 * i)) prio[i] <= reg_wdata[PRIO_W-1:0];
        end
        case (reg_addr)
          8'h84:   m_en  <= reg_wdata[NSRC:1];
          8'h88:   s_en  <= reg_wdata[NSRC:1];
          8'h8C:   m_thr <= reg_wdata[PRIO_W-1:0];
          8'h90:   s_thr <= reg_wdata[PRIO_W-1:0];
          default: ;
        endcase
      end
      // Gateway: a claim takes precedence over a same-cycle set.
      for (int i = 1; i <= NSRC; i++) begin
        if (clm_vec[i]) begin
          pending[i]   <= 1'b0;
          in_flight[i] <= 1'b1;
        end else begin
          if (irq_src[i-1] && !in_flight[i] && !pending[i]) pending[i] <= 1'b1;
          if (cmp_vec[i]) in_flight[i] <= 1'b0;
        end
      end
      m_best_q  <= m_best_c;
      s_best_q  <= s_best_c;
      m_ext_int <= (m_best_c != '0);
      s_ext_int <= (s_best_c != '0);
    end
  end

endmodule
